apb_test_regfile: RTL and testbench

- Parameterised APB completer register bank. It is the responder end of the APB requester sequences issued across the SCCB bridge.
- Replaces the zero-wait dummy peripheral in bridge sims and bring-up builds with one that exercises the harder cases: wait states, byte strobes, error responses, a read-only ID register and observable state.
- Sits on the device-side apb_req port of an SCCB bridge, or any APB requester.

---
 rtl/apb_test_regfile_if.sv | 23 ++
 rtl/apb_test_regfile.sv | 97 +++++++++
 tb/tb_apb_test_regfile.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_test_regfile_if.sv
// APB bus bundle between a requester and the apb_test_regfile completer.
interface apb_test_regfile_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_test_regfile.sv
// APB completer register bank with configurable wait states, byte strobes,
// error responses, a read-only ID word at index 0 and observable state.
module apb_test_regfile #(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'h5CCB_0001
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    apb_test_regfile_if.slave       apb,
    output logic [32*NUM_REGS-1:0]  regs_out,
    output logic [15:0]             wr_count,
    output logic                    err_pulse
);

    localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned WCNT_W  = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned LANES   = 4;

    logic [31:0]       regs_q [NUM_REGS];
    logic [WCNT_W-1:0] wait_cnt;
    logic              acc;
    logic              pready_int;
    logic              err;
    logic              wr_en;
    logic [29:0]       idx_full;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       rd_word;
    logic              unused_pprot;

    assign unused_pprot = ^apb.pprot;

    // Access detect, wait-state completion and address decode
    assign acc        = apb.psel && apb.penable;
    assign pready_int = acc && (wait_cnt == WCNT_W'(WAIT_STATES));
    assign idx_full   = apb.paddr[31:2];
    assign idx        = idx_full[IDX_W-1:0];
    assign err        = (apb.paddr[1:0] != 2'b00)
                     || (idx_full >= 30'(NUM_REGS))
                     || (apb.pwrite && (idx_full == 30'd0));
    assign wr_en      = pready_int && apb.pwrite && !err;
    assign rd_word    = (idx == IDX_W'(0)) ? ID_VALUE : regs_q[idx];

    // Bus responses are held low for the whole time reset is asserted
    assign apb.pready  = preset_n && pready_int;
    assign apb.pslverr = preset_n && pready_int && err;
    assign apb.prdata  = (preset_n && pready_int && !apb.pwrite && !err) ? rd_word : 32'd0;

    // Wait counter restarts whenever the access ends or completes
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wait_cnt <= '0;
        end else if (!acc || pready_int) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
        end
    end

    // Byte-lane write into the addressed register
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < int'(LANES); b++) begin
                if (apb.pstrb[b]) begin
                    regs_q[idx][8*b +: 8] <= apb.pwdata[8*b +: 8];
                end
            end
        end
    end

    // Saturating commit counter and registered error pulse
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wr_count  <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= pready_int && err;
            if (wr_en && (wr_count != {CNT_W{1'b1}})) begin
                wr_count <= wr_count + CNT_W'(1);
            end
        end
    end

    for (genvar r = 0; r < int'(NUM_REGS); r++) begin : g_regs_out
        if (r == 0) begin : g_id
            assign regs_out[32*r +: 32] = ID_VALUE;
        end else begin : g_reg
            assign regs_out[32*r +: 32] = regs_q[r];
        end
    end

endmodule

// File: tb/tb_apb_test_regfile.sv
// Directed bench for apb_test_regfile: three instances with 0, 3 and 4 wait states.
module tb_apb_test_regfile;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic [2:0]  sel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;

    int total  = 0;
    int passed = 0;

    apb_test_regfile_if bus0 ();
    apb_test_regfile_if bus3 ();
    apb_test_regfile_if bus4 ();

    logic [32*16-1:0] regs0, regs3, regs4;
    logic [15:0]      wrc0, wrc3, wrc4;
    logic             errp0, errp3, errp4;

    assign bus0.psel = sel[0];
    assign bus3.psel = sel[1];
    assign bus4.psel = sel[2];
    assign bus0.penable = penable; assign bus3.penable = penable; assign bus4.penable = penable;
    assign bus0.pwrite  = pwrite;  assign bus3.pwrite  = pwrite;  assign bus4.pwrite  = pwrite;
    assign bus0.paddr   = paddr;   assign bus3.paddr   = paddr;   assign bus4.paddr   = paddr;
    assign bus0.pwdata  = pwdata;  assign bus3.pwdata  = pwdata;  assign bus4.pwdata  = pwdata;
    assign bus0.pstrb   = pstrb;   assign bus3.pstrb   = pstrb;   assign bus4.pstrb   = pstrb;
    assign bus0.pprot   = 3'b000;  assign bus3.pprot   = 3'b010;  assign bus4.pprot   = 3'b111;

    apb_test_regfile #(.NUM_REGS(16), .WAIT_STATES(0)) u0 (
        .pclk(pclk), .preset_n(preset_n), .apb(bus0.slave),
        .regs_out(regs0), .wr_count(wrc0), .err_pulse(errp0));
    apb_test_regfile #(.NUM_REGS(16), .WAIT_STATES(3)) u3 (
        .pclk(pclk), .preset_n(preset_n), .apb(bus3.slave),
        .regs_out(regs3), .wr_count(wrc3), .err_pulse(errp3));
    apb_test_regfile #(.NUM_REGS(16), .WAIT_STATES(4)) u4 (
        .pclk(pclk), .preset_n(preset_n), .apb(bus4.slave),
        .regs_out(regs4), .wr_count(wrc4), .err_pulse(errp4));

    always #5 pclk = ~pclk;

    function automatic logic rdy(input int d);
        case (d)
            0:       return bus0.pready;
            1:       return bus3.pready;
            default: return bus4.pready;
        endcase
    endfunction

    function automatic logic [31:0] word(input int d, input int i);
        case (d)
            0:       return regs0[32*i +: 32];
            1:       return regs3[32*i +: 32];
            default: return regs4[32*i +: 32];
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One APB transfer on instance d; returns data/err at the pready cycle and
    // the target register value seen just before the commit edge.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        output logic [31:0] rdata, output logic err,
                        output int waits, output logic [31:0] pre);
        logic done;
        done  = 1'b0;
        waits = 0;
        rdata = '0;
        err   = 1'b0;
        pre   = '0;
        @(negedge pclk);
        sel = 3'(1 << d); penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = data; pstrb = strb;
        @(negedge pclk);
        penable = 1'b1;
        for (int i = 0; i < 32 && !done; i++) begin
            #1;
            if (rdy(d)) begin
                done = 1'b1;
                case (d)
                    0:       begin rdata = bus0.prdata; err = bus0.pslverr; end
                    1:       begin rdata = bus3.prdata; err = bus3.pslverr; end
                    default: begin rdata = bus4.prdata; err = bus4.pslverr; end
                endcase
                pre = word(d, int'(addr[5:2]));
            end else begin
                waits++;
                @(negedge pclk);
            end
        end
        if (!done) check("pready_timeout", 32'(done), 32'd1);
        @(negedge pclk);
        sel = 3'b000; penable = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, pre;
        logic        er;
        int          w;

        preset_n = 1'b0; sel = '0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (2) @(negedge pclk);
        #1;
        check("rst_pready", 32'(bus0.pready), 32'd0);
        check("rst_wr_count", 32'(wrc0), 32'd0);
        check("rst_err_pulse", 32'(errp0), 32'd0);
        check("rst_id_slot", word(0, 0), 32'h5CCB_0001);
        check("rst_reg1", word(0, 1), 32'd0);
        @(negedge pclk);
        preset_n = 1'b1;

        // Zero-wait write then read-back
        xfer(0, 1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, rd, er, w, pre);
        check("ws0_wr_waits", 32'(w), 32'd0);
        check("ws0_wr_err", 32'(er), 32'd0);
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, w, pre);
        check("ws0_rd_waits", 32'(w), 32'd0);
        check("ws0_rd_data", rd, 32'hDEAD_BEEF);
        check("ws0_rd_err", 32'(er), 32'd0);
        check("ws0_wr_count", 32'(wrc0), 32'd1);

        // Three wait states; data lands only at the pready edge
        xfer(1, 1'b1, 32'h8, 32'hFEED_FACE, 4'hF, rd, er, w, pre);
        check("ws3_waits", 32'(w), 32'd3);
        check("ws3_pre_commit", pre, 32'd0);
        #1;
        check("ws3_reg2", word(1, 2), 32'hFEED_FACE);
        check("ws3_wr_count", 32'(wrc3), 32'd1);

        // Byte strobes
        xfer(0, 1'b1, 32'hC, 32'h1122_3344, 4'hF, rd, er, w, pre);
        xfer(0, 1'b1, 32'hC, 32'hAABB_CCDD, 4'b0101, rd, er, w, pre);
        #1;
        check("strb_reg3", word(0, 3), 32'h11BB_33DD);
        xfer(0, 1'b1, 32'hC, 32'hFFFF_FFFF, 4'b0000, rd, er, w, pre);
        #1;
        check("strb0_err", 32'(er), 32'd0);
        check("strb0_reg3", word(0, 3), 32'h11BB_33DD);
        check("strb0_wr_count", 32'(wrc0), 32'd4);

        // Out-of-range read
        xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, w, pre);
        check("oor_err", 32'(er), 32'd1);
        check("oor_rdata", rd, 32'd0);
        #1;
        check("oor_err_pulse", 32'(errp0), 32'd1);
        @(negedge pclk); #1;
        check("oor_err_pulse_end", 32'(errp0), 32'd0);

        // ID register is read-only
        xfer(0, 1'b1, 32'h0, 32'h1234_5678, 4'hF, rd, er, w, pre);
        check("id_wr_err", 32'(er), 32'd1);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, w, pre);
        check("id_rd_err", 32'(er), 32'd0);
        check("id_rd_data", rd, 32'h5CCB_0001);

        // Misaligned write
        xfer(0, 1'b1, 32'h6, 32'hFFFF_FFFF, 4'hF, rd, er, w, pre);
        #1;
        check("mis_err", 32'(er), 32'd1);
        check("mis_reg1", word(0, 1), 32'hDEAD_BEEF);
        check("err_wr_count", 32'(wrc0), 32'd4);

        // Requester abort after two access cycles
        @(negedge pclk);
        sel = 3'b100; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h10; pwdata = 32'h1234_5678; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        check("abort_rdy_a", 32'(bus4.pready), 32'd0);
        @(negedge pclk); #1;
        check("abort_rdy_b", 32'(bus4.pready), 32'd0);
        @(negedge pclk);
        sel = 3'b000; penable = 1'b0;
        @(negedge pclk); #1;
        check("abort_reg4", word(2, 4), 32'd0);
        check("abort_wr_count", 32'(wrc4), 32'd0);
        check("abort_err_pulse", 32'(errp4), 32'd0);
        xfer(2, 1'b1, 32'h10, 32'h1234_5678, 4'hF, rd, er, w, pre);
        #1;
        check("ws4_waits", 32'(w), 32'd4);
        check("ws4_reg4", word(2, 4), 32'h1234_5678);

        // Reset mid-wait with select/enable held on an erroring read
        @(negedge pclk);
        sel = 3'b011; penable = 1'b0; pwrite = 1'b0; paddr = 32'h40;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        #2 preset_n = 1'b0;
        #1;
        check("rstmid_rdy0", 32'(bus0.pready), 32'd0);
        check("rstmid_err0", 32'(bus0.pslverr), 32'd0);
        check("rstmid_rdy3", 32'(bus3.pready), 32'd0);
        check("rstmid_reg1", word(0, 1), 32'd0);
        check("rstmid_reg2_u3", word(1, 2), 32'd0);
        check("rstmid_wrc0", 32'(wrc0), 32'd0);
        check("rstmid_wrc3", 32'(wrc3), 32'd0);
        @(negedge pclk);
        sel = 3'b000; penable = 1'b0;
        @(negedge pclk);
        preset_n = 1'b1;
        xfer(1, 1'b1, 32'h8, 32'hCAFE_0001, 4'hF, rd, er, w, pre);
        check("post_rst_waits", 32'(w), 32'd3);

        // Saturate wr_count by holding a zero-wait write access
        @(negedge pclk);
        sel = 3'b001; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h4; pwdata = 32'h0000_0001; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        repeat (65540) @(negedge pclk);
        sel = 3'b000; penable = 1'b0;
        #1;
        check("sat_wr_count", 32'(wrc0), 32'h0000_FFFF);
        xfer(0, 1'b1, 32'h8, 32'h0000_0002, 4'hF, rd, er, w, pre);
        #1;
        check("sat_hold", 32'(wrc0), 32'h0000_FFFF);
        check("sat_reg2", word(0, 2), 32'h0000_0002);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
